// File: rtl/fetch_decode_exec.sv
// rtl/fetch_decode_exec.sv - single-cycle RV64I fetch, decode and execute datapath
module fetch_decode_exec #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] RESET_NOP = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [XLEN-1:0] i_pc,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_ins,
    output logic [4:0]      o_rs1id,
    output logic [4:0]      o_rs2id,
    output logic [4:0]      o_rdid,
    output logic            o_rdwen,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic [XLEN-1:0] o_imm,
    output logic [3:0]      o_lsu_opt,
    output logic            o_brch,
    output logic            o_jal,
    output logic            o_jalr,
    output logic [XLEN-1:0] o_exu_res,
    output logic            o_zero,
    output logic            o_ebreak,
    output logic            o_illegal
);

    typedef enum logic [2:0] {
        EX_ZERO, EX_IMM, EX_PC_IMM, EX_PC4, EX_ADDR, EX_ALU, EX_ALUW, EX_BRANCH
    } ex_sel_e;

    logic            fetch_en;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic            writes;
    logic            op_imm;
    ex_sel_e         ex_sel;
    logic [XLEN-1:0] alu_a, alu_b, alu_res, aluw_res;
    logic [31:0]     w_res;
    logic            alt, lt_s, lt_u, taken;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) fetch_en <= 1'b0;
        else          fetch_en <= 1'b1;
    end

    assign o_imem_addr = i_pc;
    assign o_ins       = fetch_en ? i_imem_rdata : RESET_NOP;

    assign opcode  = o_ins[6:0];
    assign funct3  = o_ins[14:12];
    assign funct7  = o_ins[31:25];
    assign o_rdid  = o_ins[11:7];
    assign o_rs1id = o_ins[19:15];
    assign o_rs2id = o_ins[24:20];

    assign imm_i = {{(XLEN-12){o_ins[31]}}, o_ins[31:20]};
    assign imm_s = {{(XLEN-12){o_ins[31]}}, o_ins[31:25], o_ins[11:7]};
    assign imm_b = {{(XLEN-12){o_ins[31]}}, o_ins[7], o_ins[30:25], o_ins[11:8], 1'b0};
    assign imm_u = {{(XLEN-32){o_ins[31]}}, o_ins[31:12], 12'b0};
    assign imm_j = {{(XLEN-20){o_ins[31]}}, o_ins[19:12], o_ins[20], o_ins[30:21], 1'b0};

    always_comb begin
        o_imm     = '0;
        o_lsu_opt = 4'b1111;
        o_brch    = 1'b0;
        o_jal     = 1'b0;
        o_jalr    = 1'b0;
        o_ebreak  = 1'b0;
        o_illegal = 1'b0;
        writes    = 1'b0;
        op_imm    = 1'b0;
        ex_sel    = EX_ZERO;
        case (opcode)
            7'b0110111: begin writes = 1'b1; o_imm = imm_u; ex_sel = EX_IMM; end
            7'b0010111: begin writes = 1'b1; o_imm = imm_u; ex_sel = EX_PC_IMM; end
            7'b1101111: begin writes = 1'b1; o_imm = imm_j; o_jal = 1'b1; ex_sel = EX_PC4; end
            7'b1100111: begin
                o_imm = imm_i;
                if (funct3 == 3'b000) begin writes = 1'b1; o_jalr = 1'b1; ex_sel = EX_PC4; end
                else o_illegal = 1'b1;
            end
            7'b1100011: begin
                o_imm = imm_b;
                if (funct3[2:1] == 2'b01) o_illegal = 1'b1;
                else begin o_brch = 1'b1; ex_sel = EX_BRANCH; end
            end
            7'b0000011: begin
                o_imm = imm_i;
                if (funct3 == 3'b111) o_illegal = 1'b1;
                else begin writes = 1'b1; o_lsu_opt = {funct3, 1'b0}; ex_sel = EX_ADDR; end
            end
            7'b0100011: begin
                o_imm = imm_s;
                if (funct3[2]) o_illegal = 1'b1;
                else begin o_lsu_opt = {funct3 + 3'd1, 1'b1}; ex_sel = EX_ADDR; end
            end
            7'b0010011: begin
                o_imm  = imm_i;
                op_imm = 1'b1;
                if ((funct3 == 3'b001 && o_ins[31:26] != 6'b0) ||
                    (funct3 == 3'b101 && o_ins[31:26] != 6'b0 && o_ins[31:26] != 6'b010000))
                    o_illegal = 1'b1;
                else begin writes = 1'b1; ex_sel = EX_ALU; end
            end
            7'b0011011: begin
                o_imm  = imm_i;
                op_imm = 1'b1;
                if (funct3 == 3'b000 || (funct3 == 3'b001 && funct7 == 7'b0) ||
                    (funct3 == 3'b101 && (funct7 == 7'b0 || funct7 == 7'b0100000)))
                    begin writes = 1'b1; ex_sel = EX_ALUW; end
                else o_illegal = 1'b1;
            end
            7'b0110011: begin
                if (funct7 == 7'b0 ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                    begin writes = 1'b1; ex_sel = EX_ALU; end
                else o_illegal = 1'b1;
            end
            7'b0111011: begin
                if ((funct3 == 3'b000 || funct3 == 3'b101) && (funct7 == 7'b0 || funct7 == 7'b0100000) ||
                    (funct3 == 3'b001 && funct7 == 7'b0))
                    begin writes = 1'b1; ex_sel = EX_ALUW; end
                else o_illegal = 1'b1;
            end
            7'b1110011: begin
                if (o_ins == 32'h0010_0073)      o_ebreak  = 1'b1;
                else if (o_ins != 32'h0000_0073) o_illegal = 1'b1;
            end
            7'b0001111: if (funct3 != 3'b000) o_illegal = 1'b1;
            default:    o_illegal = 1'b1;
        endcase
        // An illegal encoding must not leak partial decode into the LSU or flags
        if (o_illegal) begin
            o_lsu_opt = 4'b1111;
            o_brch    = 1'b0;
            o_jal     = 1'b0;
            o_jalr    = 1'b0;
            writes    = 1'b0;
            ex_sel    = EX_ZERO;
        end
    end

    assign o_rdwen = writes && (o_rdid != 5'd0);

    assign alu_a = i_rs1;
    assign alu_b = op_imm ? o_imm : i_rs2;
    // bit 30 is an immediate bit for most OP-IMM forms, so only shifts and OP use it as sub/sra
    assign alt   = o_ins[30] & (opcode[5] | (funct3 == 3'b101));
    assign lt_s  = $signed(alu_a) < $signed(alu_b);
    assign lt_u  = alu_a < alu_b;

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alt ? alu_a - alu_b : alu_a + alu_b;
            3'b001: alu_res = alu_a << alu_b[5:0];
            3'b010: alu_res = {{(XLEN-1){1'b0}}, lt_s};
            3'b011: alu_res = {{(XLEN-1){1'b0}}, lt_u};
            3'b100: alu_res = alu_a ^ alu_b;
            3'b101: alu_res = alt ? XLEN'($signed(alu_a) >>> alu_b[5:0]) : alu_a >> alu_b[5:0];
            3'b110: alu_res = alu_a | alu_b;
            3'b111: alu_res = alu_a & alu_b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        w_res = '0;
        case (funct3)
            3'b001:  w_res = alu_a[31:0] << alu_b[4:0];
            3'b101:  w_res = alt ? 32'($signed(alu_a[31:0]) >>> alu_b[4:0]) : alu_a[31:0] >> alu_b[4:0];
            default: w_res = alt ? alu_a[31:0] - alu_b[31:0] : alu_a[31:0] + alu_b[31:0];
        endcase
    end

    assign aluw_res = {{(XLEN-32){w_res[31]}}, w_res};

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = (i_rs1 == i_rs2);
            3'b001:  taken = (i_rs1 != i_rs2);
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = lt_u;
            3'b111:  taken = !lt_u;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        o_exu_res = '0;
        case (ex_sel)
            EX_IMM:    o_exu_res = o_imm;
            EX_PC_IMM: o_exu_res = i_pc + o_imm;
            EX_PC4:    o_exu_res = i_pc + XLEN'(4);
            EX_ADDR:   o_exu_res = i_rs1 + o_imm;
            EX_ALU:    o_exu_res = alu_res;
            EX_ALUW:   o_exu_res = aluw_res;
            EX_BRANCH: o_exu_res = taken ? '0 : XLEN'(1);
            default:   o_exu_res = '0;
        endcase
    end

    assign o_zero = (o_exu_res == '0);

endmodule

// File: tb/tb_fetch_decode_exec.sv
// tb/tb_fetch_decode_exec.sv - directed scoreboard bench for fetch_decode_exec
module tb_fetch_decode_exec;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [63:0] i_pc;
    logic [63:0] o_imem_addr;
    logic [31:0] i_imem_rdata;
    logic [31:0] o_ins;
    logic [4:0]  o_rs1id, o_rs2id, o_rdid;
    logic        o_rdwen;
    logic [63:0] i_rs1, i_rs2;
    logic [63:0] o_imm;
    logic [3:0]  o_lsu_opt;
    logic        o_brch, o_jal, o_jalr;
    logic [63:0] o_exu_res;
    logic        o_zero, o_ebreak, o_illegal;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] ins;
        logic [4:0]  rdid;
        logic        rdwen;
        logic        chk_imm;
        logic [63:0] imm;
        logic [3:0]  lsu;
        logic [4:0]  flags;
        logic [63:0] res;
        logic        zero;
        logic [63:0] addr;
    } exp_t;

    exp_t sb[$];

    fetch_decode_exec dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pc(i_pc), .o_imem_addr(o_imem_addr),
        .i_imem_rdata(i_imem_rdata), .o_ins(o_ins), .o_rs1id(o_rs1id), .o_rs2id(o_rs2id),
        .o_rdid(o_rdid), .o_rdwen(o_rdwen), .i_rs1(i_rs1), .i_rs2(i_rs2), .o_imm(o_imm),
        .o_lsu_opt(o_lsu_opt), .o_brch(o_brch), .o_jal(o_jal), .o_jalr(o_jalr),
        .o_exu_res(o_exu_res), .o_zero(o_zero), .o_ebreak(o_ebreak), .o_illegal(o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic cmp(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s.%s observed=%h expected=%h", tag, fld, obs, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic [31:0] ins, input logic [4:0] rdid,
                            input logic rdwen, input logic chk_imm, input logic [63:0] imm,
                            input logic [3:0] lsu, input logic [4:0] flags, input logic [63:0] res);
        exp_t e;
        e.tag = tag; e.ins = ins; e.rdid = rdid; e.rdwen = rdwen; e.chk_imm = chk_imm;
        e.imm = imm; e.lsu = lsu; e.flags = flags; e.res = res;
        e.zero = (res == 64'd0);
        e.addr = i_pc;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        n_cmp++;
        assert (sb.size() > 0) else begin
            n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            cmp(e.tag, "ins",   64'(o_ins), 64'(e.ins));
            cmp(e.tag, "addr",  o_imem_addr, e.addr);
            cmp(e.tag, "rdid",  64'(o_rdid), 64'(e.rdid));
            cmp(e.tag, "rdwen", 64'(o_rdwen), 64'(e.rdwen));
            if (e.chk_imm) cmp(e.tag, "imm", o_imm, e.imm);
            cmp(e.tag, "lsu",   64'(o_lsu_opt), 64'(e.lsu));
            cmp(e.tag, "flags", 64'({o_brch, o_jal, o_jalr, o_ebreak, o_illegal}), 64'(e.flags));
            cmp(e.tag, "res",   o_exu_res, e.res);
            cmp(e.tag, "zero",  64'(o_zero), 64'(e.zero));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // flags are packed as {brch, jal, jalr, ebreak, illegal}
    initial begin
        i_rst_n = 1'b0; i_pc = 64'h1000; i_imem_rdata = 32'hFFF0_0093;
        i_rs1 = 64'h55; i_rs2 = 64'h0;
        exp_push("reset_nop", 32'h13, 5'd0, 1'b0, 1'b1, 64'd0, 4'hF, 5'b0, 64'h55);
        #2; check_out();
        repeat (2) @(posedge i_clk);
        #1;
        exp_push("reset_hold", 32'h13, 5'd0, 1'b0, 1'b1, 64'd0, 4'hF, 5'b0, 64'h55);
        check_out();

        @(negedge i_clk); i_rst_n = 1'b1;
        exp_push("pre_edge", 32'h13, 5'd0, 1'b0, 1'b1, 64'd0, 4'hF, 5'b0, 64'h55);
        #1; check_out();
        i_rs1 = 64'h0;
        exp_push("addi_m1", 32'hFFF0_0093, 5'd1, 1'b1, 1'b1, '1, 4'hF, 5'b0, '1);
        @(posedge i_clk); #1; check_out();

        @(negedge i_clk);
        i_imem_rdata = 32'h0020_81BB; i_rs1 = 64'h7FFF_FFFF; i_rs2 = 64'h1;
        exp_push("addw", 32'h0020_81BB, 5'd3, 1'b1, 1'b0, 64'd0, 4'hF, 5'b0, 64'hFFFF_FFFF_8000_0000);
        #1; check_out();
        cmp("addw", "rs1id", 64'(o_rs1id), 64'd1);
        cmp("addw", "rs2id", 64'(o_rs2id), 64'd2);

        @(negedge i_clk);
        i_imem_rdata = 32'h0020_8463; i_rs1 = 64'd5; i_rs2 = 64'd5;
        exp_push("beq_taken", 32'h0020_8463, 5'd8, 1'b0, 1'b1, 64'd8, 4'hF, 5'b10000, 64'd0);
        #1; check_out();
        i_rs2 = 64'd6;
        exp_push("beq_not", 32'h0020_8463, 5'd8, 1'b0, 1'b1, 64'd8, 4'hF, 5'b10000, 64'd1);
        #1; check_out();

        i_imem_rdata = 32'h0020_E463; i_rs1 = 64'd1; i_rs2 = '1;
        exp_push("bltu_taken", 32'h0020_E463, 5'd8, 1'b0, 1'b1, 64'd8, 4'hF, 5'b10000, 64'd0);
        #1; check_out();
        i_imem_rdata = 32'h0020_D463;
        exp_push("bge_signed", 32'h0020_D463, 5'd8, 1'b0, 1'b1, 64'd8, 4'hF, 5'b10000, 64'd0);
        #1; check_out();
        i_rs1 = '1; i_rs2 = 64'd1;
        exp_push("bge_not", 32'h0020_D463, 5'd8, 1'b0, 1'b1, 64'd8, 4'hF, 5'b10000, 64'd1);
        #1; check_out();

        @(negedge i_clk);
        i_imem_rdata = 32'h0080_00EF; i_pc = 64'h8000_0000;
        exp_push("jal", 32'h0080_00EF, 5'd1, 1'b1, 1'b1, 64'd8, 4'hF, 5'b01000, 64'h8000_0004);
        #1; check_out();

        i_imem_rdata = 32'h0021_B823; i_rs1 = 64'h100; i_pc = 64'h8000_0004;
        exp_push("sd", 32'h0021_B823, 5'd16, 1'b0, 1'b1, 64'd16, 4'b1001, 5'b0, 64'h110);
        #1; check_out();

        i_imem_rdata = 32'hFF80_B203; i_rs1 = 64'h1000;
        exp_push("ld_neg", 32'hFF80_B203, 5'd4, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 4'b0110, 5'b0, 64'hFF8);
        #1; check_out();

        @(negedge i_clk);
        i_imem_rdata = 32'h4043_529B; i_rs1 = 64'h8000_0000;
        exp_push("sraiw", 32'h4043_529B, 5'd5, 1'b1, 1'b1, 64'h404, 4'hF, 5'b0, 64'hFFFF_FFFF_F800_0000);
        #1; check_out();
        i_imem_rdata = 32'h0043_529B;
        exp_push("srliw", 32'h0043_529B, 5'd5, 1'b1, 1'b1, 64'h4, 4'hF, 5'b0, 64'h0800_0000);
        #1; check_out();

        i_imem_rdata = 32'h4020_8033; i_rs1 = 64'd3; i_rs2 = 64'd5;
        exp_push("sub_x0", 32'h4020_8033, 5'd0, 1'b0, 1'b0, 64'd0, 4'hF, 5'b0, 64'hFFFF_FFFF_FFFF_FFFE);
        #1; check_out();

        @(negedge i_clk);
        i_imem_rdata = 32'h0010_0073;
        exp_push("ebreak", 32'h0010_0073, 5'd0, 1'b0, 1'b0, 64'd0, 4'hF, 5'b00010, 64'd0);
        #1; check_out();
        i_imem_rdata = 32'hFFFF_FFFF;
        exp_push("illegal", 32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0, 64'd0, 4'hF, 5'b00001, 64'd0);
        #1; check_out();

        @(negedge i_clk); #2;
        i_rst_n = 1'b0; i_imem_rdata = 32'hFFF0_0093; i_rs1 = 64'h77;
        exp_push("async_rst", 32'h13, 5'd0, 1'b0, 1'b1, 64'd0, 4'hF, 5'b0, 64'h77);
        #1; check_out();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
